// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: byte hand-off from the UART receiver to the downstream stage.
interface uart_byte_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    modport master (output rx_data, rx_valid, rx_frame_err, rx_overrun, input rx_ready);
    modport slave  (input rx_data, rx_valid, rx_frame_err, rx_overrun, output rx_ready);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with mid-bit sampling, valid/ready holding register
// and one-cycle frame-error / overrun pulses.
module uart_byte_rx #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 57_600,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           rx_pin,
    uart_byte_rx_if.master bus
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int TW       = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t          state, nstate;
    logic [1:0]      sync;
    logic            rx_s;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [7:0]      data;
    logic            valid, frame_err, overrun;
    logic            timer_end, half_end, stop_hit, load, ov_set, fe_set;

    assign rx_s      = sync[1];
    assign timer_end = timer == TW'(CLKS_PER_BIT - 1);
    assign half_end  = timer == TW'(HALF_BIT - 1);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sync  <= 2'b11;
            state <= IDLE;
        end else begin
            sync  <= {sync[0], rx_pin};
            state <= nstate;
        end
    end

    // BRK holds off a stuck-low line so it cannot look like a stream of starts
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = rx_s ? IDLE : START;
            START:   nstate = half_end ? (rx_s ? IDLE : DATA) : START;
            DATA:    nstate = (timer_end && bit_idx == 3'd7) ? STOP : DATA;
            STOP:    nstate = timer_end ? (rx_s ? IDLE : BRK) : STOP;
            BRK:     nstate = rx_s ? IDLE : BRK;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            timer   <= (state == IDLE || state == BRK || nstate != state || timer_end) ? '0 : timer + TW'(1);
            bit_idx <= (state == START) ? 3'd0 : (state == DATA && timer_end) ? bit_idx + 3'd1 : bit_idx;
            shreg   <= (state == DATA && timer_end) ? {rx_s, shreg[7:1]} : shreg;
        end
    end

    always_comb begin
        stop_hit = state == STOP && timer_end;
        load     = stop_hit && rx_s && (!valid || bus.rx_ready);
        ov_set   = stop_hit && rx_s && valid && !bus.rx_ready;
        fe_set   = stop_hit && !rx_s;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            data      <= load ? shreg : data;
            valid     <= load | (valid & ~bus.rx_ready);
            frame_err <= fe_set;
            overrun   <= ov_set;
        end
    end

    assign bus.rx_data      = data;
    assign bus.rx_valid     = valid;
    assign bus.rx_frame_err = frame_err;
    assign bus.rx_overrun   = overrun;
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed scenarios for uart_byte_rx at a shortened bit period (32 clocks).
module tb_uart_byte_rx;
    localparam int CPB  = 32;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic clk = 1'b0, reset = 1'b0, rx_pin = 1'b1;
    int total = 0, bad = 0;
    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, wide_cnt = 0, rise_cnt = 0;
    logic fe_q = 1'b0, ov_q = 1'b0, v_q = 1'b0;
    logic [7:0] got[$];

    uart_byte_rx_if u();
    uart_byte_rx #(.CLK_HZ(100_000_000), .BAUD(3_125_000)) dut (
        .CLK(clk), .reset(reset), .rx_pin(rx_pin), .bus(u.master));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u.rx_frame_err) fe_cnt++;
        if (u.rx_overrun) ov_cnt++;
        if (u.rx_frame_err && u.rx_overrun) both_cnt++;
        if ((u.rx_frame_err && fe_q) || (u.rx_overrun && ov_q)) wide_cnt++;
        if (u.rx_valid && !v_q) begin
            rise_cnt++;
            got.push_back(u.rx_data);
        end
        fe_q = u.rx_frame_err;
        ov_q = u.rx_overrun;
        v_q  = u.rx_valid;
    end

    task automatic send(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(negedge clk) rx_pin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_pin = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset;
        u.rx_ready = 1'b0;
        #100;
        total++; if (u.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", u.rx_valid); end
        total++; if (u.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", u.rx_data); end
        total++; if ({u.rx_frame_err, u.rx_overrun} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {u.rx_frame_err, u.rx_overrun}); end
        @(negedge clk) reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_latency;
        int n = 0;
        int f0 = fe_cnt, o0 = ov_cnt;
        fork
            send(8'hF4);
            begin
                @(negedge clk);
                while (!u.rx_valid && n < LAT + 20) begin @(posedge clk); #1; n++; end
            end
        join
        total++; if (n < LAT - 2 || n > LAT + 2) begin bad++; $display("FAIL latency got=%0d exp=%0d", n, LAT); end
        total++; if (u.rx_data !== 8'hF4) begin bad++; $display("FAIL latency_data got=%h exp=f4", u.rx_data); end
        total++; if (fe_cnt != f0 || ov_cnt != o0) begin bad++; $display("FAIL latency_err got=%0d/%0d exp=%0d/%0d", fe_cnt, ov_cnt, f0, o0); end
        @(negedge clk) u.rx_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (u.rx_valid !== 1'b0) begin bad++; $display("FAIL ready_clear got=%b exp=0", u.rx_valid); end
        u.rx_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [4] = '{8'h7E, 8'h03, 8'h55, 8'h57};
        int r0 = rise_cnt, o0 = ov_cnt;
        got.delete();
        u.rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(exp_b[i]);
            repeat (10) @(negedge clk);
        end
        total++; if (rise_cnt - r0 != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", rise_cnt - r0); end
        for (int i = 0; i < 4; i++) begin
            total++; if (got.size() <= i || got[i] !== exp_b[i]) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, got.size() > i ? got[i] : 8'hxx, exp_b[i]); end
        end
        total++; if (ov_cnt != o0) begin bad++; $display("FAIL b2b_overrun got=%0d exp=%0d", ov_cnt, o0); end
    endtask

    task automatic test_glitch;
        int r0 = rise_cnt, f0 = fe_cnt;
        @(negedge clk) rx_pin = 1'b0;
        repeat (HALF - 3) @(negedge clk);
        rx_pin = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        total++; if (rise_cnt != r0 || fe_cnt != f0) begin bad++; $display("FAIL glitch got=%0d/%0d exp=%0d/%0d", rise_cnt, fe_cnt, r0, f0); end
        got.delete();
        send(8'h3C);
        repeat (4) @(negedge clk);
        total++; if (got.size() != 1 || got[0] !== 8'h3C) begin bad++; $display("FAIL glitch_idle got=%0d/%h exp=1/3c", got.size(), got.size() > 0 ? got[0] : 8'hxx); end
    endtask

    task automatic test_frame_error;
        int f0 = fe_cnt;
        got.delete();
        send(8'h41, 1'b0);
        repeat (5 * CPB) @(negedge clk);
        rx_pin = 1'b1;
        repeat (CPB) @(negedge clk);
        total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL frame_err_pulses got=%0d exp=1", fe_cnt - f0); end
        total++; if (got.size() != 0) begin bad++; $display("FAIL frame_err_valid got=%0d exp=0", got.size()); end
        send(8'hC0);
        repeat (CPB) @(negedge clk);
        total++; if (got.size() != 1 || got[0] !== 8'hC0) begin bad++; $display("FAIL after_break got=%0d/%h exp=1/c0", got.size(), got.size() > 0 ? got[0] : 8'hxx); end
        total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL break_extra_err got=%0d exp=1", fe_cnt - f0); end
    endtask

    task automatic test_overrun;
        int o0, r0;
        u.rx_ready = 1'b0;
        send(8'hFE);
        repeat (4) @(negedge clk);
        total++; if (u.rx_valid !== 1'b1 || u.rx_data !== 8'hFE) begin bad++; $display("FAIL hold_first got=%b/%h exp=1/fe", u.rx_valid, u.rx_data); end
        o0 = ov_cnt;
        send(8'hFC);
        repeat (4) @(negedge clk);
        total++; if (ov_cnt - o0 != 1) begin bad++; $display("FAIL overrun_pulse got=%0d exp=1", ov_cnt - o0); end
        total++; if (u.rx_valid !== 1'b1 || u.rx_data !== 8'hFE) begin bad++; $display("FAIL overrun_keep got=%b/%h exp=1/fe", u.rx_valid, u.rx_data); end
        o0 = ov_cnt;
        r0 = rise_cnt;
        fork
            send(8'hFF);
            begin
                @(negedge clk);
                repeat (LAT - 1) @(negedge clk);
                u.rx_ready = 1'b1;
                @(negedge clk) u.rx_ready = 1'b0;
            end
        join
        total++; if (u.rx_valid !== 1'b1 || u.rx_data !== 8'hFF) begin bad++; $display("FAIL swap_data got=%b/%h exp=1/ff", u.rx_valid, u.rx_data); end
        total++; if (rise_cnt != r0) begin bad++; $display("FAIL swap_valid_dip got=%0d exp=%0d", rise_cnt, r0); end
        total++; if (ov_cnt != o0) begin bad++; $display("FAIL swap_overrun got=%0d exp=%0d", ov_cnt, o0); end
    endtask

    task automatic test_mid_reset;
        int r0 = 0;
        fork
            send(8'hF0);
            begin
                @(negedge clk);
                repeat (5 * CPB + HALF) @(negedge clk);
                reset = 1'b0;
                #1;
                total++; if (u.rx_valid !== 1'b0 || u.rx_data !== 8'h00) begin bad++; $display("FAIL midreset_out got=%b/%h exp=0/00", u.rx_valid, u.rx_data); end
                total++; if ({u.rx_frame_err, u.rx_overrun} !== 2'b00) begin bad++; $display("FAIL midreset_err got=%b exp=00", {u.rx_frame_err, u.rx_overrun}); end
                repeat (3) @(negedge clk);
                reset = 1'b1;
                r0 = rise_cnt;
            end
        join
        repeat (CPB) @(negedge clk);
        total++; if (rise_cnt != r0) begin bad++; $display("FAIL midreset_partial got=%0d exp=%0d", rise_cnt, r0); end
        send(8'h06);
        repeat (4) @(negedge clk);
        total++; if (rise_cnt - r0 != 1 || u.rx_valid !== 1'b1 || u.rx_data !== 8'h06) begin bad++; $display("FAIL after_reset got=%0d/%b/%h exp=1/1/06", rise_cnt - r0, u.rx_valid, u.rx_data); end
    endtask

    task automatic test_pulses;
        total++; if (both_cnt != 0) begin bad++; $display("FAIL err_overlap got=%0d exp=0", both_cnt); end
        total++; if (wide_cnt != 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", wide_cnt); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_overrun;
        test_mid_reset;
        test_pulses;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
